button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
- REQ-001: Parameter NUM_BTN, default 4; number of independent button channels.
- REQ-002: Parameter DEBOUNCE_CYCLES, default 120000; consecutive stable cycles required to accept a level change (10 ms at 12 MHz).
- REQ-003: Parameter ACTIVE_LOW_MASK, default 4'b1000; bit i set means raw input i is active-low (BTN_N on bit 3).
- REQ-004: Parameters REPEAT_DELAY (default 6000000) and REPEAT_PERIOD (default 1200000); cycles to first repeat, then cycles between repeats.
- REQ-005: Port CLK, input, 1; sole clock, all logic on rising edge.
- REQ-006: Port RST, input, 1; synchronous, active-high reset.
- REQ-007: Port btn_raw, input, NUM_BTN; asynchronous raw pad levels.
- REQ-008: Port btn_level, output, NUM_BTN; debounced pressed level, 1 = pressed, polarity normalised.
- REQ-009: Port btn_press, output, NUM_BTN; one-cycle pulse on accepted press (and on repeat, when compiled in).
- REQ-010: Port btn_release, output, NUM_BTN; one-cycle pulse on accepted release.

Function
- REQ-011: Each btn_raw bit SHALL pass through a 2-flop synchroniser, then be XORed with its ACTIVE_LOW_MASK bit.
- REQ-012: Each channel SHALL implement FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- REQ-013: RELEASED -> PRESS_WAIT when synced input = 1; PRESS_WAIT -> RELEASED if input returns to 0 before count completes.
- REQ-014: PRESS_WAIT -> PRESSED after DEBOUNCE_CYCLES consecutive cycles with input = 1; btn_level rises and btn_press pulses in the transition cycle.
- REQ-015: PRESSED -> RELEASE_WAIT when input = 0; RELEASE_WAIT -> PRESSED on any input = 1 before count completes, without a pulse.
- REQ-016: RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES consecutive cycles with input = 0; btn_level falls and btn_release pulses in that cycle.
- REQ-017: Debounce counter SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits, clear on entry to each WAIT state and on abort, and never wrap.
- REQ-018: Latency from a clean pad edge to btn_level/pulse SHALL be exactly DEBOUNCE_CYCLES + 2 cycles.
- REQ-019: Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.
- REQ-020: btn_press and btn_release SHALL never be high together on one channel, and never high for two consecutive cycles.

Reset
- REQ-021: RST SHALL force all channels to RELEASED, clear counters and synchronisers to the inactive level, and drive btn_level, btn_press, btn_release to 0 in the following cycle.
- REQ-022: RST asserted mid-debounce or mid-hold SHALL discard the pending event; a button held through reset release SHALL be re-debounced and produce exactly one btn_press.

Configuration
- REQ-023: Macro BUTTON_DEBOUNCE_REPEAT_EN defined: in PRESSED, btn_press SHALL re-pulse REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD cycles, while held; the repeat counter clears on leaving PRESSED, and RELEASE_WAIT -> PRESSED resumes it from zero.
- REQ-024: Macro undefined: no repeat counter is built, and exactly one btn_press per accepted press.

Structure
- REQ-025: Shared package button_pkg SHALL hold the channel state enum, the default DEBOUNCE_CYCLES, and the default REPEAT_DELAY/REPEAT_PERIOD constants.
- REQ-026: Per-channel logic (synchroniser, FSM, counters) SHALL be sub-module debounce_channel, instantiated NUM_BTN times by generate.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
- REQ-027: Clean press on bit 0 at cycle 0 -> btn_level[0] rises and btn_press[0] pulses at cycle 10; release at cycle 30 -> btn_release[0] pulses at cycle 40.
- REQ-028: Bounce of 1,0,1,0 every 3 cycles, then steady 1 -> exactly one btn_press, 10 cycles after the final 0->1 edge.
- REQ-029: Bit 3 (active-low) driven 0 -> btn_level[3] = 1 after 10 cycles; driven 1 -> btn_level[3] = 0.
- REQ-030: All four pressed in the same cycle -> btn_press = 4'b1111 for one cycle.
- REQ-031: RST pulsed at cycle 5 of PRESS_WAIT with button still held -> no pulse before reset; one btn_press 10 cycles after RST deasserts.
- REQ-032: With BUTTON_DEBOUNCE_REPEAT_EN, hold for 60 cycles after acceptance -> btn_press pulses at +0, +20, +25, +30 ... +60; without the macro -> only the +0 pulse.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the button debounce block.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 120000;
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 6000000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 1200000;

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, polarity fix, 4-state debounce FSM.
// Auto-repeat of btn_press is built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        ACTIVE_LOW      = 1'b0,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Entering a WAIT state is the first stable cycle, so the wait ends D-1 cycles later.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 2) : 0);
  localparam bit DIRECT = (DEBOUNCE_CYCLES <= 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 2 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("debounce_channel: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  logic [1:0]       sync;
  logic             pressed_in;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RPT_W-1:0] rpt_cnt;
`endif

  always_ff @(posedge CLK) begin
    if (RST) sync <= {2{ACTIVE_LOW}};
    else     sync <= {sync[0], btn_raw};
  end

  assign pressed_in = sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RELEASED;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      rpt_cnt     <= '0;
`endif
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (pressed_in) begin
            cnt <= '0;
            if (DIRECT) begin
              state     <= PRESSED;
              btn_level <= 1'b1;
              btn_press <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (!pressed_in) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed_in) begin
            cnt <= '0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            rpt_cnt <= '0;
`endif
            if (DIRECT) begin
              state       <= RELEASED;
              btn_level   <= 1'b0;
              btn_release <= 1'b1;
            end else begin
              state <= RELEASE_WAIT;
            end
          end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
          // Reloading to DELAY-PERIOD makes later repeats land every PERIOD cycles.
          else if (rpt_cnt == RPT_FIRE) begin
            btn_press <= 1'b1;
            rpt_cnt   <= RPT_RELOAD;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (pressed_in) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer with normalised polarity and press/release pulses.
// Define BUTTON_DEBOUNCE_REPEAT_EN to build auto-repeat on held buttons.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned         NUM_BTN         = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [NUM_BTN-1:0]  ACTIVE_LOW_MASK = 4'b1000,
  parameter int unsigned         REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned         REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .CLK         (CLK),
      .RST         (RST),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule
